// File: rtl/pipe_seq_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
package pipe_seq_pkg;

   localparam int unsigned REG_W  = 4;   // architectural register index width
   localparam int unsigned WCNT_W = 4;   // SRAM wait counter width

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_WAIT = 1'b1
   } state_e;

endpackage

// File: rtl/hazard_detect.sv
// Combinational RAW hazard detector between the ID sources and the EXE/MEM destinations.
// Ports: id_src1/id_src2/id_two_src (ID reads), exe_*/mem_* (producer writes),
//        forward_en (forwarding active), raw (hazard present).
module hazard_detect
   import pipe_seq_pkg::*;
(
   input  logic [REG_W-1:0] id_src1,
   input  logic [REG_W-1:0] id_src2,
   input  logic             id_two_src,
   input  logic             exe_wb_en,
   input  logic [REG_W-1:0] exe_dest,
   input  logic             exe_mem_r_en,
   input  logic             mem_wb_en,
   input  logic [REG_W-1:0] mem_dest,
   input  logic             forward_en,
   output logic             raw
);

   logic exe_m1, exe_m2, mem_m1, mem_m2;

   // With forwarding only a load in EXE cannot be bypassed in time (load-use).
   always_comb begin
      exe_m1 = exe_wb_en && (exe_dest == id_src1);
      exe_m2 = exe_wb_en && (exe_dest == id_src2);
      mem_m1 = mem_wb_en && (mem_dest == id_src1);
      mem_m2 = mem_wb_en && (mem_dest == id_src2);
      raw    = 1'b0;
      if (forward_en) begin
         raw = exe_mem_r_en && (exe_m1 || (id_two_src && exe_m2));
      end else begin
         raw = exe_m1 || mem_m1 || (id_two_src && (exe_m2 || mem_m2));
      end
   end

endmodule

// File: rtl/pipeline_sequencer.sv
// Central stall/flush sequencer: RAW hazard stalls, multi-cycle SRAM freeze, branch flush,
// and saturating stall/flush performance counters.
// Ports: clk/rst (async active-low), hazard sources (id_*, exe_*, mem_*, forward_en),
//        mem_access, exe_branch, perf_clr; outputs hazard, freeze_*, wb_bubble, flush,
//        mem_busy (registered), stall_cycles, flush_count.
module pipeline_sequencer
   import pipe_seq_pkg::*;
#(
   parameter int unsigned MEM_LATENCY = 6,
   parameter int unsigned CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [REG_W-1:0] id_src1,
   input  logic [REG_W-1:0] id_src2,
   input  logic             id_two_src,
   input  logic             exe_wb_en,
   input  logic [REG_W-1:0] exe_dest,
   input  logic             exe_mem_r_en,
   input  logic             mem_wb_en,
   input  logic [REG_W-1:0] mem_dest,
   input  logic             mem_access,
   input  logic             exe_branch,
   input  logic             forward_en,
   input  logic             perf_clr,
   output logic             hazard,
   output logic             freeze_pc,
   output logic             freeze_if_id,
   output logic             freeze_id_exe,
   output logic             freeze_exe_mem,
   output logic             wb_bubble,
   output logic             flush,
   output logic             mem_busy,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] flush_count
);

   state_e             state_q, state_d;
   logic [WCNT_W-1:0]  cnt_q, cnt_d;
   logic [CNT_W-1:0]   stall_q, stall_d;
   logic [CNT_W-1:0]   flush_q, flush_d;
   logic               mem_stall;
   logic               raw;

   hazard_detect u_hazard_detect (
      .id_src1      (id_src1),
      .id_src2      (id_src2),
      .id_two_src   (id_two_src),
      .exe_wb_en    (exe_wb_en),
      .exe_dest     (exe_dest),
      .exe_mem_r_en (exe_mem_r_en),
      .mem_wb_en    (mem_wb_en),
      .mem_dest     (mem_dest),
      .forward_en   (forward_en),
      .raw          (raw)
   );

   // State, wait counter and performance counters.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_RUN;
         cnt_q   <= '0;
         stall_q <= '0;
         flush_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         stall_q <= stall_d;
         flush_q <= flush_d;
      end
   end

   // SRAM access sequencing: one RUN cycle plus MEM_LATENCY-2 counted WAIT cycles stall,
   // the final WAIT cycle (cnt==0) releases the pipeline.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      mem_stall = 1'b0;
      case (state_q)
         ST_RUN: begin
            if (mem_access && (MEM_LATENCY >= 2)) begin
               mem_stall = 1'b1;
               cnt_d     = WCNT_W'(MEM_LATENCY - 2);
               state_d   = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (cnt_q != '0) begin
               mem_stall = 1'b1;
               cnt_d     = cnt_q - WCNT_W'(1);
            end else begin
               state_d   = ST_RUN;
            end
         end
         default: state_d = ST_RUN;
      endcase
   end

   // Priority: SRAM stall masks everything; a flush squashes the hazard-stalled instruction.
   always_comb begin
      flush          = exe_branch && !mem_stall;
      hazard         = raw && !mem_stall && !flush;
      freeze_pc      = mem_stall || hazard;
      freeze_if_id   = mem_stall || hazard;
      freeze_id_exe  = mem_stall;
      freeze_exe_mem = mem_stall;
      wb_bubble      = mem_stall;
   end

   // Saturating counters; clear wins over increment.
   always_comb begin
      stall_d = stall_q;
      flush_d = flush_q;
      if (perf_clr) begin
         stall_d = '0;
         flush_d = '0;
      end else begin
         if (freeze_pc && (stall_q != {CNT_W{1'b1}})) stall_d = stall_q + CNT_W'(1);
         if (flush && (flush_q != {CNT_W{1'b1}}))     flush_d = flush_q + CNT_W'(1);
      end
   end

   assign mem_busy     = (state_q == ST_WAIT);
   assign stall_cycles = stall_q;
   assign flush_count  = flush_q;

endmodule

// File: doc/pipeline_sequencer.md
Name: pipeline_sequencer

Overview:
Central stall/flush sequencer for the 5-stage ARM pipeline.
- Detects RAW hazards between ID sources and EXE/MEM destinations and drives the ID-stage hazard input.
- Sequences multi-cycle SRAM accesses in MEM by freezing the upstream pipeline for a fixed latency.
- Flushes IF/ID and ID/EXE on a taken branch in EXE, and keeps stall/flush performance counters.

Parameters:
MEM_LATENCY, 6, total cycles one SRAM access occupies in MEM (legal range 1..15; 1 means no stall)
CNT_W, 32, width of the performance counters

Ports:
clk  in  1  pipeline clock, rising edge
rst  in  1  asynchronous reset, active-low
id_src1  in  4  Rn of instruction in ID
id_src2  in  4  second source in ID (the ID stage's Rm/Rd-for-STR selection)
id_two_src  in  1  ID instruction reads id_src2
exe_wb_en  in  1  EXE instruction writes back
exe_dest  in  4  EXE destination
exe_mem_r_en  in  1  EXE instruction is a load
mem_wb_en  in  1  MEM instruction writes back
mem_dest  in  4  MEM destination
mem_access  in  1  MEM instruction is LDR/STR
exe_branch  in  1  taken branch in EXE
forward_en  in  1  forwarding unit active
perf_clr  in  1  synchronous clear of counters
hazard  out  1  to ID stage: zero control signals
freeze_pc  out  1  hold PC
freeze_if_id  out  1  hold IF/ID register
freeze_id_exe  out  1  hold ID/EXE register
freeze_exe_mem  out  1  hold EXE/MEM register
wb_bubble  out  1  load NOP into MEM/WB
flush  out  1  clear IF/ID and ID/EXE
mem_busy  out  1  registered: FSM in WAIT
stall_cycles  out  CNT_W  cycles with freeze_pc=1
flush_count  out  CNT_W  cycles with flush=1

Behaviour:
- Reset (rst=0, async): FSM=RUN, wait counter=0, counters=0. All combinational outputs evaluate to 0 given the reset state and idle inputs.
- FSM states: RUN, WAIT. Wait counter is 4 bits.
  - RUN, mem_access=1, MEM_LATENCY>=2: mem_stall=1 this cycle; cnt<=MEM_LATENCY-2; next state WAIT.
  - WAIT, cnt!=0: mem_stall=1; cnt<=cnt-1.
  - WAIT, cnt==0: mem_stall=0 (access completes); next state RUN. mem_access is not examined in this cycle.
  - Result: exactly MEM_LATENCY-1 stall cycles per access. Back-to-back accesses each pay the full latency. MEM_LATENCY=1 keeps the FSM in RUN permanently.
- mem_stall=1 drives freeze_pc, freeze_if_id, freeze_id_exe, freeze_exe_mem and wb_bubble all to 1, and forces hazard=0 and flush=0. A branch held in EXE takes effect on the release cycle.
- raw (combinational), with forward_en=0: raw = (exe_wb_en & exe_dest==id_src1) | (mem_wb_en & mem_dest==id_src1) | (id_two_src & ((exe_wb_en & exe_dest==id_src2) | (mem_wb_en & mem_dest==id_src2))).
- raw with forward_en=1: same expression restricted to EXE-stage matches, each additionally qualified with exe_mem_r_en (load-use only).
- flush = exe_branch & ~mem_stall.
- hazard = raw & ~mem_stall & ~flush. Flush overrides hazard because the stalled instruction is squashed anyway.
- In a hazard cycle: freeze_pc=1, freeze_if_id=1, hazard=1. freeze_id_exe stays 0 so a bubble enters EXE.
- freeze_pc = mem_stall | hazard.
- mem_busy = registered (state==WAIT).
- Counters:
  - stall_cycles increments on each edge where freeze_pc=1.
  - flush_count increments on each edge where flush=1.
  - Both saturate at all-ones. perf_clr=1 clears both to 0 and takes priority over increment.
- Reset asserted mid-WAIT: immediate return to RUN; no partial state is retained.

Decomposition:
- Package pipe_seq_pkg holds the FSM state encoding (RUN=1'b0, WAIT=1'b1) and the wait-counter width constant.
- One natural sub-module: hazard_detect, purely combinational, producing raw from the source/destination/enable/forward inputs. The FSM, priority logic and counters stay in the top module.

Test Plan:
- Reset: hold rst=0 with exe_branch=1 and mem_access=1, release at idle -> all outputs 0, counters 0, mem_busy 0.
- RAW, no forwarding: id_src1=3, exe_wb_en=1, exe_dest=3, forward_en=0 -> hazard=1, freeze_pc=1, freeze_id_exe=0; stall_cycles=1 after one edge.
- Load-use with forwarding: forward_en=1, exe_mem_r_en=1, exe_dest=5, id_two_src=1, id_src2=5 -> hazard=1. Clear exe_mem_r_en -> hazard=0. MEM-stage match alone -> hazard=0.
- SRAM access, MEM_LATENCY=6: pulse mem_access while in RUN -> 5 consecutive cycles with all freezes and wb_bubble=1, mem_busy high for 5 cycles starting one cycle later, release in the 6th cycle; stall_cycles=5.
- Branch during stall: exe_branch=1 from the first mem_stall cycle -> flush=0 for 5 cycles, flush=1 on the release cycle, flush_count=1. With hazard also asserted in that cycle -> hazard=0.
- Async reset mid-WAIT (cnt=3): assert rst=0 between edges -> freezes drop immediately, FSM RUN; after release, a new mem_access stalls the full 5 cycles.
